seq_serializer: RTL and testbench

Parallel-to-serial stage that sits directly upstream of the 1011 sequence detector and drives its serial input x. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock. Back-to-back words stream with no idle gap, so patterns that straddle a word boundary still reach the detector intact.

---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_serializer.sv | 112 +++++++++++
 tb/tb_seq_serializer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the serializer and the downstream 1011 detector.
// Both blocks and their benches import this so the pattern is defined once.
package seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic       IDLE_FILL_DEFAULT = 1'b0;
  localparam logic [3:0] DETECT_PATTERN    = 4'b1011;

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial stage feeding the 1011 detector: first bit on x the cycle after accept,
// one bit per clock, WIDTH cycles per word; load_ready only in IDLE or on a word's last bit.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_FILL = IDLE_FILL_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic             r_x;
  logic             w_x_nxt;
  logic             r_x_valid;
  logic             w_x_valid_nxt;
  logic             w_last;
  logic             w_accept;
  logic             w_load_bit;
  logic             w_next_bit;
  logic             w_do_load;

  // Outputs depend on registered state only, so there is no input-to-output path.
  assign w_last     = (r_state == SHIFT) && (r_cnt == '0);
  assign load_ready = (r_state == IDLE) || w_last;
  assign busy       = (r_state == SHIFT);
  assign done       = w_last;
  assign x          = r_x;
  assign x_valid    = r_x_valid;

  assign w_accept   = load_valid && load_ready;
  assign w_shifted  = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
  assign w_load_bit = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
  assign w_next_bit = MSB_FIRST ? w_shifted[WIDTH-1] : w_shifted[0];

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_shreg_nxt   = r_shreg;
    w_x_nxt       = r_x;
    w_x_valid_nxt = r_x_valid;
    w_do_load     = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_do_load = 1'b1;
        end
      end
      SHIFT: begin
        if (r_cnt != '0) begin
          w_shreg_nxt = w_shifted;
          w_x_nxt     = w_next_bit;
          w_cnt_nxt   = r_cnt - CW'(1);
        end else if (w_accept) begin
          w_do_load = 1'b1;
        end else begin
          w_x_nxt       = IDLE_FILL;
          w_x_valid_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Loading from IDLE and chaining on the last bit are identical, which keeps the stream gapless.
    if (w_do_load) begin
      w_shreg_nxt   = load_data;
      w_x_nxt       = w_load_bit;
      w_x_valid_nxt = 1'b1;
      w_cnt_nxt     = CNT_LAST;
      w_state_nxt   = SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shreg   <= '0;
      r_x       <= IDLE_FILL;
      r_x_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_shreg   <= w_shreg_nxt;
      r_x       <= w_x_nxt;
      r_x_valid <= w_x_valid_nxt;
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: three configurations driven from one vector table,
// plus hand-written sequences for reset and the chained-detector pattern.
module tb_seq_serializer;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lv  = 1'b0;
  logic [7:0] d   = 8'h00;
  int         cur = 0;

  logic lv_a, lv_b, lv_c;
  logic rdy_a, x_a, xv_a, bz_a, dn_a;
  logic rdy_b, x_b, xv_b, bz_b, dn_b;
  logic rdy_c, x_c, xv_c, bz_c, dn_c;
  logic o_rdy, o_x, o_xv, o_bz, o_dn;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign lv_a = lv && (cur == 0);
  assign lv_b = lv && (cur == 1);
  assign lv_c = lv && (cur == 2);

  seq_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_FILL(1'b0)) u_a (
    .clk(clk), .rst(rst), .load_valid(lv_a), .load_ready(rdy_a), .load_data(d[3:0]),
    .x(x_a), .x_valid(xv_a), .busy(bz_a), .done(dn_a));

  seq_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_FILL(1'b0)) u_b (
    .clk(clk), .rst(rst), .load_valid(lv_b), .load_ready(rdy_b), .load_data(d[3:0]),
    .x(x_b), .x_valid(xv_b), .busy(bz_b), .done(dn_b));

  seq_serializer u_c (
    .clk(clk), .rst(rst), .load_valid(lv_c), .load_ready(rdy_c), .load_data(d),
    .x(x_c), .x_valid(xv_c), .busy(bz_c), .done(dn_c));

  always_comb begin
    o_rdy = rdy_a; o_x = x_a; o_xv = xv_a; o_bz = bz_a; o_dn = dn_a;
    if (cur == 1) begin
      o_rdy = rdy_b; o_x = x_b; o_xv = xv_b; o_bz = bz_b; o_dn = dn_b;
    end else if (cur == 2) begin
      o_rdy = rdy_c; o_x = x_c; o_xv = xv_c; o_bz = bz_c; o_dn = dn_c;
    end
  end

  typedef struct {
    int         sel;
    int         tag;
    logic       lv;
    logic [7:0] d;
    logic       x;
    logic       xv;
    logic       bz;
    logic       dn;
    logic       rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int sel, int tag, logic v, logic [7:0] dd,
                              logic ex, logic exv, logic ebz, logic edn, logic erdy);
    vec_t r;
    r.sel = sel; r.tag = tag; r.lv = v; r.d = dd;
    r.x = ex; r.xv = exv; r.bz = ebz; r.dn = edn; r.rdy = erdy;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic ex, input logic exv,
                           input logic ebz, input logic edn, input logic erdy);
    check({tag, ".x"},          32'(o_x),   32'(ex));
    check({tag, ".x_valid"},    32'(o_xv),  32'(exv));
    check({tag, ".busy"},       32'(o_bz),  32'(ebz));
    check({tag, ".done"},       32'(o_dn),  32'(edn));
    check({tag, ".load_ready"}, 32'(o_rdy), 32'(erdy));
  endtask

  logic [3:0] hist;
  int         det_hits;
  int         det_pos;
  int         det_bits;
  logic [7:0] word;

  initial begin
    // Columns: sel, tag, load_valid, load_data | expected after the edge: x, x_valid, busy, done, load_ready
    // Plan 1: W4 MSB-first 1011, single-cycle load.
    tbl.push_back(mk(0, 1, 1, 8'h0B, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 0, 1));
    // Plan 2: 1101 then 0110 with load_valid held; no gap between words.
    tbl.push_back(mk(0, 2, 1, 8'h0D, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 2, 1, 8'h06, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 2, 1, 8'h06, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 2, 1, 8'h06, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 2, 1, 8'h06, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 2, 0, 8'h00, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 2, 0, 8'h00, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 2, 0, 8'h00, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0, 2, 0, 8'h00, 0, 0, 0, 0, 1));
    // Plan 3: 1111, then 0000 offered while not ready; taken only at the end of cycle 4.
    tbl.push_back(mk(0, 3, 1, 8'h0F, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 3, 1, 8'h00, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 3, 1, 8'h00, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 3, 1, 8'h00, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 3, 1, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 3, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 3, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 3, 0, 8'h00, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0, 3, 0, 8'h00, 0, 0, 0, 0, 1));
    // Plan 4: W4 LSB-first 1101 -> 1,0,1,1.
    tbl.push_back(mk(1, 4, 1, 8'h0D, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4, 0, 8'h00, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4, 0, 8'h00, 1, 1, 1, 1, 1));
    tbl.push_back(mk(1, 4, 0, 8'h00, 0, 0, 0, 0, 1));
    // Plan 5: W8 default B5 -> 1,0,1,1,0,1,0,1.
    tbl.push_back(mk(2, 5, 1, 8'hB5, 1, 1, 1, 0, 0));
    tbl.push_back(mk(2, 5, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(mk(2, 5, 0, 8'h00, 1, 1, 1, 0, 0));
    tbl.push_back(mk(2, 5, 0, 8'h00, 1, 1, 1, 0, 0));
    tbl.push_back(mk(2, 5, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(mk(2, 5, 0, 8'h00, 1, 1, 1, 0, 0));
    tbl.push_back(mk(2, 5, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(mk(2, 5, 0, 8'h00, 1, 1, 1, 1, 1));
    tbl.push_back(mk(2, 5, 0, 8'h00, 0, 0, 0, 0, 1));

    hist     = 4'b0000;
    det_hits = 0;
    det_pos  = 0;
    det_bits = 0;

    // Reset state, observed while reset is still asserted.
    #12;
    for (int s = 0; s < 3; s++) begin
      cur = s;
      #1;
      check_all($sformatf("reset%0d", s), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    cur = 0;
    @(negedge clk);
    rst = 1'b1;
    step();
    check("post_reset.load_ready", 32'(o_rdy), 32'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      cur = tbl[i].sel;
      lv  = tbl[i].lv;
      d   = tbl[i].d;
      step();
      check_all($sformatf("vec%0d_plan%0d", i, tbl[i].tag),
                tbl[i].x, tbl[i].xv, tbl[i].bz, tbl[i].dn, tbl[i].rdy);
      if (tbl[i].tag == 2 && o_xv) begin
        det_bits++;
        hist = {hist[2:0], o_x};
        if (hist == DETECT_PATTERN) begin
          det_hits++;
          det_pos = det_bits;
        end
      end
    end
    lv = 1'b0;
    check("detector_hits", 32'(det_hits), 32'd1);
    check("detector_pos",  32'(det_pos),  32'd7);

    // Plan 6: async reset mid-word while the 3rd bit of B5 is on x.
    cur = 2;
    lv  = 1'b1;
    d   = 8'hB5;
    step();
    lv = 1'b0;
    check("rst_seq.bit1", 32'(o_x), 32'd1);
    step();
    check("rst_seq.bit2", 32'(o_x), 32'd0);
    step();
    check("rst_seq.bit3", 32'(o_x), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_async.x",       32'(o_x),  32'd0);
    check("rst_async.x_valid", 32'(o_xv), 32'd0);
    check("rst_async.busy",    32'(o_bz), 32'd0);
    #3 rst = 1'b1;
    step();
    check_all("rst_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    word = 8'hB5;
    lv   = 1'b1;
    d    = word;
    for (int b = 7; b >= 0; b--) begin
      step();
      lv = 1'b0;
      check_all($sformatf("reload_bit%0d", b), word[b], 1'b1, 1'b1, (b == 0), (b == 0));
    end
    step();
    check_all("reload_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
